univ_reg: RTL and testbench
===========================

UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..36.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into Q on reset; WIDTH bits wide.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset; asynchronous, active-high.
REQ-005 MODE  input  1  operating mode: 0 = counter, 1 = shift register.
REQ-006 SEL  input  [0:1]  operation select: 00 LOAD, 01 DEC/shift toward bit WIDTH-1, 10 INC/shift toward bit 0, 11 HOLD.
REQ-007 CIN  input  1  count enable / carry-in; used only in counter mode.
REQ-008 D  input  [0:WIDTH-1]  parallel load data; bit 0 is the MSB.
REQ-009 S0  input  1  serial input entering bit 0 on SEL=01 shifts.
REQ-010 SN  input  1  serial input entering bit WIDTH-1 on SEL=10 shifts.
REQ-011 Q  output  [0:WIDTH-1]  register contents; bit 0 is the MSB.
REQ-012 COUT  output  1  carry/borrow-out for cascading; combinational.

Function
REQ-013 SEL=00 in either mode: Q <= D on the next edge; CIN, S0 and SN are ignored.
REQ-014 SEL=11 in either mode: Q holds.
REQ-015 Counter, SEL=10, CIN=1: Q <= Q+1 modulo 2^WIDTH; all-ones wraps to zero.
REQ-016 Counter, SEL=01, CIN=1: Q <= Q-1 modulo 2^WIDTH; zero wraps to all-ones.
REQ-017 Counter, SEL=01 or 10 with CIN=0: Q holds.
REQ-018 COUT = CIN & ((SEL=10 & Q all-ones) | (SEL=01 & Q all-zeros)).
REQ-019 COUT = 0 when SEL is 00 or 11, and whenever MODE=1.
REQ-020 COUT depends only on current Q, SEL, CIN and MODE; no register sits in its path.
REQ-021 Chaining COUT to a more-significant stage's CIN on a shared CLK gives a correct multi-stage counter with no extra latency.
REQ-022 Shift, SEL=01: next Q[0] = S0; next Q[i] = Q[i-1] for i=1..WIDTH-1; old Q[WIDTH-1] is discarded.
REQ-023 Shift, SEL=10: next Q[WIDTH-1] = SN; next Q[i] = Q[i+1] for i=0..WIDTH-2; old Q[0] is discarded.
REQ-024 Shift mode ignores CIN.
REQ-025 A MODE change takes effect on the same edge; no history is kept across a mode change.
REQ-026 Operation latency is exactly one CLK edge; Q is valid after the edge, with no wait states.

Reset
REQ-027 While RESET=1: Q = RESET_VALUE immediately, without waiting for a CLK edge; clock edges are ignored.
REQ-028 COUT during reset follows REQ-018 evaluated on Q = RESET_VALUE.
REQ-029 RESET asserted mid-operation: an in-flight load, count or shift is abandoned, with no partial update.
REQ-030 First operation after deassertion occurs on the first CLK rising edge with RESET=0.

Verification
REQ-031 WIDTH=4, MODE=0, CIN=1: LOAD 0101, then 8 x DEC -> Q steps 0100,0011,0010,0001,0000,1111,1110,1101.
  - COUT=1 only while Q=0000 with SEL=01.
REQ-032 Continue from REQ-031 with 8 x INC -> Q returns to 0101, passing 1111->0000 with COUT=1 at 1111.
  - Then 4 x HOLD -> Q stays 0101.
  - Then INC with CIN=0 -> Q stays 0101 and COUT=0.
REQ-033 WIDTH=4, MODE=1: LOAD 0101.
  - SEL=01 with S0=1 -> 1010; SEL=01 with S0=0 -> 0101.
  - SEL=10 with SN=0 -> 1010; then 4 x SEL=10 with SN=1 -> 0101,1011,0111,1111.
  - Then 4 x SEL=01 with S0=0 -> 0000; LOAD 0011 -> 0011.
REQ-034 Two WIDTH=4 instances cascaded (low COUT -> high CIN, low CIN=1): LOAD 0000_1110, 2 x INC -> 0001_0000.
  - Then 1 x DEC -> 0000_1111.
REQ-035 WIDTH=8, RESET_VALUE=0xA5: assert RESET between clock edges -> Q=10100101 before the next edge.
  - RESET held across a clock edge with SEL=10, CIN=1 -> Q unchanged.
  - After release, one INC -> 10100110.
REQ-036 Mid-count reset: with WIDTH=4 counting, assert RESET for 3 ns, not spanning any edge -> Q=RESET_VALUE at once.
  - Next edge applies the SEL operation to RESET_VALUE.

Source files
------------

// File: rtl/univ_reg.sv
// Universal register: parallel load, up/down counter with a cascadable carry/borrow,
// or bidirectional shift register. Bit 0 of D/Q is the most significant bit.
module univ_reg #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             MODE,
   input  logic [0:1]       SEL,
   input  logic             CIN,
   input  logic [0:WIDTH-1] D,
   input  logic             S0,
   input  logic             SN,
   output logic [0:WIDTH-1] Q,
   output logic             COUT
);

   localparam logic [0:1] SEL_LOAD = 2'b00;
   localparam logic [0:1] SEL_DN   = 2'b01;
   localparam logic [0:1] SEL_UP   = 2'b10;

   localparam logic [0:WIDTH-1] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [0:WIDTH-1] q_next;
   logic             at_max;
   logic             at_min;

   assign at_max = &Q;
   assign at_min = ~|Q;

   // SEL=01 moves data toward bit WIDTH-1 (numerically right), SEL=10 toward bit 0.
   always_comb begin
      q_next = Q;
      case (SEL)
         SEL_LOAD: q_next = D;
         SEL_DN: begin
            if (MODE)
               q_next = {S0, Q[0:WIDTH-2]};
            else if (CIN)
               q_next = Q - ONE;
         end
         SEL_UP: begin
            if (MODE)
               q_next = {Q[1:WIDTH-1], SN};
            else if (CIN)
               q_next = Q + ONE;
         end
         default: q_next = Q;
      endcase
   end

   // Purely combinational so a chained stage sees the carry in the same cycle.
   always_comb begin
      COUT = 1'b0;
      if (!MODE && CIN)
         COUT = ((SEL == SEL_UP) && at_max) || ((SEL == SEL_DN) && at_min);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         Q <= RESET_VALUE;
      else
         Q <= q_next;
   end

endmodule

// File: tb/tb_univ_reg.sv
// Bench for univ_reg: directed sequences with literal expectations plus randomized
// traffic against an arithmetic reference model, on 4-bit, 8-bit and cascaded instances.
module tb_univ_reg;

   logic       CLK = 1'b0;
   logic       rst;
   logic       mode;
   logic [1:0] sel;
   logic       cin;
   logic       s0;
   logic       sn;
   logic [3:0] d4;
   logic [7:0] d8;
   logic [7:0] dc;

   logic [3:0] q4;
   logic       cout4;
   logic [7:0] q8;
   logic       cout8;
   logic [3:0] q_lo;
   logic [3:0] q_hi;
   logic       cout_lo;
   logic       cout_hi;

   localparam logic [3:0] RV4 = 4'hF;
   localparam logic [7:0] RV8 = 8'hA5;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit chk_en   = 1'b0;

   logic [63:0] m4;
   logic [63:0] m8;
   logic [63:0] mc;

   always #5 CLK = ~CLK;

   univ_reg #(.WIDTH(4), .RESET_VALUE(RV4)) u4 (
      .CLK(CLK), .RESET(rst), .MODE(mode), .SEL(sel), .CIN(cin), .D(d4),
      .S0(s0), .SN(sn), .Q(q4), .COUT(cout4));

   univ_reg #(.WIDTH(8), .RESET_VALUE(RV8)) u8 (
      .CLK(CLK), .RESET(rst), .MODE(mode), .SEL(sel), .CIN(cin), .D(d8),
      .S0(s0), .SN(sn), .Q(q8), .COUT(cout8));

   univ_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) u_lo (
      .CLK(CLK), .RESET(rst), .MODE(mode), .SEL(sel), .CIN(cin), .D(dc[3:0]),
      .S0(s0), .SN(sn), .Q(q_lo), .COUT(cout_lo));

   univ_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) u_hi (
      .CLK(CLK), .RESET(rst), .MODE(mode), .SEL(sel), .CIN(cout_lo), .D(dc[7:4]),
      .S0(s0), .SN(sn), .Q(q_hi), .COUT(cout_hi));

   // Reference behaviour: sel value 1 = "01" (count down / shift right), 2 = "10".
   function automatic logic [63:0] ref_next(int w, logic [63:0] q, bit md, logic [1:0] sl,
                                             bit ci, logic [63:0] dd, bit si0, bit sin);
      logic [63:0] msk;
      msk = (64'd1 << w) - 64'd1;
      case (sl)
         2'd0: return dd & msk;
         2'd1: if (md) return (q >> 1) | (64'(si0) << (w - 1));
               else    return ci ? ((q - 64'd1) & msk) : q;
         2'd2: if (md) return ((q << 1) | 64'(sin)) & msk;
               else    return ci ? ((q + 64'd1) & msk) : q;
         default: return q;
      endcase
   endfunction

   function automatic logic [63:0] ref_cout(int w, logic [63:0] q, bit md, logic [1:0] sl, bit ci);
      logic [63:0] msk;
      msk = (64'd1 << w) - 64'd1;
      if (md || !ci) return 64'd0;
      return ((sl == 2'd2 && q == msk) || (sl == 2'd1 && q == 64'd0)) ? 64'd1 : 64'd0;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      m4 = 64'(RV4);
      m8 = 64'(RV8);
      mc = 64'd0;
   endtask

   // One clock edge; models advance with the inputs present at the edge.
   task automatic cycle();
      logic [63:0] hi;
      logic [63:0] lo;
      @(posedge CLK);
      if (!rst) begin
         m4 = ref_next(4, m4, mode, sel, cin, 64'(d4), s0, sn);
         m8 = ref_next(8, m8, mode, sel, cin, 64'(d8), s0, sn);
         if (!mode) begin
            mc = ref_next(8, mc, 1'b0, sel, cin, 64'(dc), 1'b0, 1'b0);
         end else begin
            hi = ref_next(4, mc >> 4, 1'b1, sel, cin, 64'(dc[7:4]), s0, sn);
            lo = ref_next(4, mc & 64'hF, 1'b1, sel, cin, 64'(dc[3:0]), s0, sn);
            mc = (hi << 4) | lo;
         end
      end
      @(negedge CLK);
   endtask

   task automatic dstep(string nm, bit md, logic [1:0] sl, bit ci, logic [3:0] dd,
                        bit si0, bit sin, logic [3:0] eq, bit ec);
      mode = md; sel = sl; cin = ci; d4 = dd; s0 = si0; sn = sin;
      cycle();
      chk({nm, " q"}, 64'(q4), 64'(eq));
      chk({nm, " cout"}, 64'(cout4), 64'(ec));
   endtask

   function automatic logic [63:0] pick(int w);
      logic [63:0] msk;
      msk = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 3))
         0: return 64'd0;
         1: return msk;
         default: return 64'($urandom) & msk;
      endcase
   endfunction

   // Continuous compare against the model, settled 2 ns after each rising edge.
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         if (chk_en) begin
            chk("u4 q", 64'(q4), m4);
            chk("u4 cout", 64'(cout4), ref_cout(4, m4, mode, sel, cin));
            chk("u8 q", 64'(q8), m8);
            chk("u8 cout", 64'(cout8), ref_cout(8, m8, mode, sel, cin));
            chk("casc q", 64'({q_hi, q_lo}), mc);
            chk("casc lo cout", 64'(cout_lo), ref_cout(4, mc & 64'hF, mode, sel, cin));
            chk("casc hi cout", 64'(cout_hi), ref_cout(8, mc, mode, sel, cin));
         end
      end
   end

   initial begin
      logic [3:0] dec_exp [8];
      logic [3:0] inc_exp [8];
      logic [3:0] shl_exp [4];
      dec_exp = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE, 4'hD};
      inc_exp = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      shl_exp = '{4'h5, 4'hB, 4'h7, 4'hF};

      rst = 1'b1; mode = 1'b0; sel = 2'b10; cin = 1'b1;
      s0 = 1'b0; sn = 1'b0; d4 = '0; d8 = '0; dc = '0;
      model_reset();
      #1;
      chk("reset q4", 64'(q4), 64'h F);
      chk("reset cout4 at all-ones", 64'(cout4), 64'd1);
      chk("reset q8", 64'(q8), 64'hA5);
      chk("reset casc", 64'({q_hi, q_lo}), 64'h00);
      chk_en = 1'b1;
      cycle();
      cycle();
      chk("reset held across edges", 64'(q4), 64'hF);
      rst = 1'b0;

      // Counter walk down through zero and back up through all-ones.
      dstep("load 0101", 1'b0, 2'b00, 1'b1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
      for (int i = 0; i < 8; i++)
         dstep("dec", 1'b0, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, dec_exp[i], dec_exp[i] == 4'h0);
      for (int i = 0; i < 8; i++)
         dstep("inc", 1'b0, 2'b10, 1'b1, 4'h0, 1'b0, 1'b0, inc_exp[i], inc_exp[i] == 4'hF);
      for (int i = 0; i < 4; i++)
         dstep("hold", 1'b0, 2'b11, 1'b1, 4'h0, 1'b1, 1'b1, 4'h5, 1'b0);
      dstep("inc cin0", 1'b0, 2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0);

      // Shift register walk.
      dstep("sh load", 1'b1, 2'b00, 1'b1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
      dstep("shr s0=1", 1'b1, 2'b01, 1'b1, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0);
      dstep("shr s0=0", 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0);
      dstep("shl sn=0", 1'b1, 2'b10, 1'b1, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0);
      for (int i = 0; i < 4; i++)
         dstep("shl sn=1", 1'b1, 2'b10, 1'b1, 4'h0, 1'b0, 1'b1, shl_exp[i], 1'b0);
      for (int i = 0; i < 4; i++)
         dstep("shr flush", 1'b1, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 4'hF >> (i + 1), 1'b0);
      dstep("sh load 0011", 1'b1, 2'b00, 1'b0, 4'h3, 1'b1, 1'b1, 4'h3, 1'b0);

      // Two-stage cascade.
      mode = 1'b0; sel = 2'b00; cin = 1'b1; dc = 8'h0E;
      cycle();
      chk("casc load", 64'({q_hi, q_lo}), 64'h0E);
      sel = 2'b10;
      cycle();
      chk("casc inc1", 64'({q_hi, q_lo}), 64'h0F);
      chk("casc lo carry", 64'(cout_lo), 64'd1);
      cycle();
      chk("casc inc2", 64'({q_hi, q_lo}), 64'h10);
      sel = 2'b01;
      cycle();
      chk("casc dec", 64'({q_hi, q_lo}), 64'h0F);

      // Asynchronous reset between edges, then held across an edge.
      sel = 2'b10; cin = 1'b1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async rst q8", 64'(q8), 64'hA5);
      cycle();
      chk("rst over edge q8", 64'(q8), 64'hA5);
      rst = 1'b0;
      cycle();
      chk("post-rst inc q8", 64'(q8), 64'hA6);

      // Short mid-count pulse; the following edge counts from the reset value.
      cycle();
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid-count rst q4", 64'(q4), 64'hF);
      #2;
      rst = 1'b0;
      cycle();
      chk("inc from reset value", 64'(q4), 64'h0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            chk("rnd rst q4", 64'(q4), m4);
            chk("rnd rst q8", 64'(q8), m8);
            #2;
            rst = 1'b0;
         end
         mode = 1'($urandom_range(0, 3) == 0);
         sel  = 2'($urandom_range(0, 3));
         cin  = 1'($urandom_range(0, 4) != 0);
         s0   = 1'($urandom);
         sn   = 1'($urandom);
         d4   = 4'(pick(4));
         d8   = 8'(pick(8));
         dc   = 8'(pick(8));
         cycle();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
